// File: rtl/fpu_sched.sv
// fpu_sched: issue scheduler between a core and a shared FP datapath.
//
// The datapath has fixed result latencies. Accepted ops are tracked in a
// 16-entry slot shift register. Entry k describes the result due k cycles
// from now. Internal ops (MOV/NEG/ABS) are computed here and retire through
// the same slots, so every writeback port cycle carries at most one op.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      core issue handshake (accept = both high)
//   req_op/req_a/req_b       FPU funct and operands
//   req_rd                   destination register
//   fpu_op_valid/op/a/b      one-cycle issue strobe to the datapath
//   fpu_res_valid/fpu_res    datapath result strobe and data
//   fpu_flush                drops datapath in-flight ops (high during rst)
//   wb_valid/wb_rd/wb_data   register-file writeback
//   err                      sticky protocol / illegal-op flag
module fpu_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        fpu_op_valid,
  output logic [5:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_res_valid,
  input  logic [31:0] fpu_res,
  output logic        fpu_flush,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic        intl;
    logic [31:0] dat;
  } slot_t;

  slot_t       slot_q [16];
  slot_t       slot_d [16];
  logic        fpu_op_valid_q, fpu_op_valid_d;
  logic [5:0]  fpu_op_q, fpu_op_d;
  logic [31:0] fpu_a_q, fpu_a_d;
  logic [31:0] fpu_b_q, fpu_b_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;
  logic [3:0]  div_cnt_q, div_cnt_d;

  logic        op_ext;
  logic        op_int;
  logic        op_long;
  logic [3:0]  op_lat;
  logic [31:0] int_res;
  logic [3:0]  land_idx;
  logic [3:0]  chk_idx;
  logic        waw;
  logic        clash;
  logic        div_stall;
  logic        accept;

  // Opcode decode: latency and internal result.
  always_comb begin
    op_ext  = 1'b0;
    op_int  = 1'b0;
    op_long = 1'b0;
    op_lat  = 4'd0;
    int_res = req_a;
    case (req_op)
      6'b000000, 6'b000001: begin op_ext = 1'b1; op_lat = 4'd5; end
      6'b000010, 6'b011000: begin op_ext = 1'b1; op_lat = 4'd3; end
      6'b000011, 6'b000100: begin op_ext = 1'b1; op_lat = 4'd12; op_long = 1'b1; end
      6'b110001, 6'b110010, 6'b110011: begin op_ext = 1'b1; op_lat = 4'd1; end
      6'b000110: begin op_int = 1'b1; int_res = req_a; end
      6'b000111: begin op_int = 1'b1; int_res = {~req_a[31], req_a[30:0]}; end
      6'b000101: begin op_int = 1'b1; int_res = {1'b0, req_a[30:0]}; end
      default: ;
    endcase
  end

  // An external op's result shows up L cycles after issue, i.e. at slot L one
  // cycle after accept. Internal ops retire the cycle after accept (slot 0).
  // The slot that will shift into the landing position is checked now.
  always_comb begin
    land_idx  = op_ext ? op_lat : 4'd0;
    chk_idx   = land_idx + 4'd1;
    waw       = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (slot_q[k].vld && (slot_q[k].rd == req_rd)) waw = 1'b1;
    end
    clash     = (op_ext || op_int) && slot_q[chk_idx].vld;
    div_stall = op_long && (div_cnt_q != 4'd0);
    req_ready = !rst && !waw && !clash && !div_stall;
    accept    = req_valid && req_ready;
  end

  always_comb begin
    for (int k = 0; k < 15; k++) slot_d[k] = slot_q[k+1];
    slot_d[15] = '0;
    if (accept && (op_ext || op_int)) begin
      slot_d[land_idx] = '{vld: 1'b1, rd: req_rd, intl: op_int, dat: int_res};
    end

    fpu_op_valid_d = accept && op_ext;
    fpu_op_d       = fpu_op_valid_d ? req_op : fpu_op_q;
    fpu_a_d        = fpu_op_valid_d ? req_a  : fpu_a_q;
    fpu_b_d        = fpu_op_valid_d ? req_b  : fpu_b_q;

    // Divider/sqrt busy window: counts down from issue to the result cycle.
    div_cnt_d = div_cnt_q;
    if (accept && op_long) div_cnt_d = 4'd12;
    else if (div_cnt_q != 4'd0) div_cnt_d = div_cnt_q - 4'd1;

    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    if (slot_q[0].vld) begin
      if (slot_q[0].intl) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = slot_q[0].rd;
        wb_data_d  = slot_q[0].dat;
      end else if (fpu_res_valid) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = slot_q[0].rd;
        wb_data_d  = fpu_res;
      end else begin
        err_d = 1'b1;  // expected result never arrived; nothing written back
      end
    end else if (fpu_res_valid) begin
      err_d = 1'b1;
    end
    if (accept && !op_ext && !op_int) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) slot_q[k] <= '0;
      fpu_op_valid_q <= 1'b0;
      fpu_op_q       <= '0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      err_q          <= 1'b0;
      div_cnt_q      <= '0;
    end else begin
      for (int k = 0; k < 16; k++) slot_q[k] <= slot_d[k];
      fpu_op_valid_q <= fpu_op_valid_d;
      fpu_op_q       <= fpu_op_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      err_q          <= err_d;
      div_cnt_q      <= div_cnt_d;
    end
  end

  assign fpu_flush    = rst;
  assign fpu_op_valid = fpu_op_valid_q;
  assign fpu_op       = fpu_op_q;
  assign fpu_a        = fpu_a_q;
  assign fpu_b        = fpu_b_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err          = err_q;

endmodule

// File: tb/tb_fpu_sched.sv
module tb_fpu_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        fpu_op_valid;
  logic [5:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_res_valid = 1'b0;
  logic [31:0] fpu_res = '0;
  logic        fpu_flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  fpu_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .fpu_op_valid(fpu_op_valid), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_res_valid(fpu_res_valid), .fpu_res(fpu_res), .fpu_flush(fpu_flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_MUL = 6'b000010, OP_DIV = 6'b000011,
                         OP_SQRT = 6'b000100, OP_ABS = 6'b000101, OP_MOV = 6'b000110,
                         OP_NEG = 6'b000111, OP_CLT = 6'b110010, OP_FTOI = 6'b011000,
                         OP_BAD = 6'b001000;

  typedef struct { logic [5:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; int cyc; } iss_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  iss_t iss_q[$];
  wb_t  wb_q[$];
  rsp_t rsp_q[$];
  logic spur = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  // Datapath latency table; 0 = computed internally, -1 = illegal.
  function automatic int lat_of(logic [5:0] op);
    case (op)
      6'b000000, 6'b000001: return 5;
      6'b000010, 6'b011000: return 3;
      6'b000011, 6'b000100: return 12;
      6'b110001, 6'b110010, 6'b110011: return 1;
      6'b000101, 6'b000110, 6'b000111: return 0;
      default: return -1;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request until accepted; acc = accept cycle. Pushes expectations.
  task automatic send(logic [5:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                      logic [31:0] res, output int acc);
    int l;
    bit ok;
    ok = 0;
    acc = -1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1;
        acc = cyc;
        l = lat_of(op);
        if (l > 0) begin
          iss_q.push_back('{op, a, b, res, acc + 1});
          wb_q.push_back('{rd, res, acc + 2 + l});
        end else if (l == 0) begin
          wb_q.push_back('{rd, res, acc + 2});
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: op %h rd %0d not accepted within 40 cycles", op, rd);
    end
  endtask

  // Datapath model: returns the directed result L cycles after issue.
  initial forever begin
    bit hit;
    logic [31:0] d;
    @(posedge clk);
    #2;
    hit = 0; d = '0;
    for (int i = 0; i < rsp_q.size(); i++) begin
      if (rsp_q[i].due == cyc) begin
        hit = 1; d = rsp_q[i].data; rsp_q.delete(i); break;
      end
    end
    fpu_res_valid = hit || spur;
    fpu_res = d;
  end

  // Issue monitor.
  always @(negedge clk) begin
    int idx;
    if (!rst) begin
      if (fpu_op_valid === 1'b1) begin
        idx = -1;
        foreach (iss_q[i]) if (iss_q[i].cyc == cyc) idx = i;
        if (idx < 0) begin
          n_chk++; n_fail++;
          $display("FAIL issue_unexpected: op %h at cycle %0d, expected no issue", fpu_op, cyc);
        end else begin
          chk("issue_op", {26'd0, fpu_op}, {26'd0, iss_q[idx].op});
          chk("issue_a", fpu_a, iss_q[idx].a);
          chk("issue_b", fpu_b, iss_q[idx].b);
          rsp_q.push_back('{cyc + lat_of(iss_q[idx].op), iss_q[idx].res});
          iss_q.delete(idx);
        end
      end
      for (int i = iss_q.size() - 1; i >= 0; i--) begin
        if (iss_q[i].cyc <= cyc) begin
          n_chk++; n_fail++;
          $display("FAIL issue_missing: op %h due cycle %0d, got no issue", iss_q[i].op, iss_q[i].cyc);
          iss_q.delete(i);
        end
      end
    end
  end

  // Writeback monitor.
  always @(negedge clk) begin
    int idx;
    if (!rst) begin
      if (wb_valid === 1'b1) begin
        idx = -1;
        foreach (wb_q[i]) if (wb_q[i].cyc == cyc) idx = i;
        if (idx < 0) begin
          n_chk++; n_fail++;
          $display("FAIL wb_unexpected: rd %0d data %h at cycle %0d, expected none", wb_rd, wb_data, cyc);
        end else begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, wb_q[idx].rd});
          chk("wb_data", wb_data, wb_q[idx].data);
          wb_q.delete(idx);
        end
      end
      for (int i = wb_q.size() - 1; i >= 0; i--) begin
        if (wb_q[i].cyc <= cyc) begin
          n_chk++; n_fail++;
          $display("FAIL wb_missing: rd %0d due cycle %0d, got no writeback", wb_q[i].rd, wb_q[i].cyc);
          wb_q.delete(i);
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_flush", {31'd0, fpu_flush}, 32'd1);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_op_valid", {31'd0, fpu_op_valid}, 32'd0);
    chk("rst_fpu_op", {26'd0, fpu_op}, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    int t0, acc, t;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_release", {31'd0, fpu_flush}, 32'd0);
    chk("ready_release", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Single ADD: 1.0 + 2.0 = 3.0
    send(OP_ADD, 32'h3F800000, 32'h40000000, 5'd3, 32'h40400000, acc);
    idle(10);
    @(negedge clk);
    chk("err_clean", {31'd0, err}, 32'd0);
    @(posedge clk); #1;

    // MUL, ADD back-to-back; second MUL collides with the ADD's due cycle.
    send(OP_MUL, 32'h40000000, 32'h40400000, 5'd1, 32'h40C00000, t0);
    send(OP_ADD, 32'h40000000, 32'h40000000, 5'd2, 32'h40800000, acc);
    chk("b2b_no_stall", acc, t0 + 1);
    idle(1);
    send(OP_MUL, 32'h40800000, 32'h40000000, 5'd4, 32'h41000000, acc);
    chk("collision_stall", acc, t0 + 4);
    idle(12);

    // DIV pending: WAW on rd5 stalls, SQRT waits for the divider.
    send(OP_DIV, 32'h40C00000, 32'h40000000, 5'd5, 32'h40400000, t0);
    req_valid = 1'b1; req_op = OP_ADD; req_rd = 5'd5;
    @(negedge clk);
    chk("waw_stall", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    send(OP_SQRT, 32'h41100000, 32'h0, 5'd6, 32'h40400000, acc);
    chk("div_busy_stall", acc, t0 + 13);
    idle(16);

    // Internal ops and a comparison.
    send(OP_NEG, 32'h40400000, 32'h0, 5'd7, 32'hC0400000, acc);
    send(OP_CLT, 32'h3F800000, 32'h40000000, 5'd8, 32'h00000001, acc);
    send(OP_ABS, 32'hC0400000, 32'h0, 5'd9, 32'h40400000, acc);
    send(OP_MOV, 32'h12345678, 32'h0, 5'd10, 32'h12345678, acc);
    send(OP_FTOI, 32'h40400000, 32'h0, 5'd11, 32'h00000003, acc);
    idle(8);

    // Spurious result strobe sets a sticky error; issue continues.
    @(negedge clk);
    chk("err_before_spur", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("err_spur", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    send(OP_ADD, 32'h3F800000, 32'h3F800000, 5'd12, 32'h40000000, acc);
    idle(8);
    @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    @(posedge clk); #1;

    // Reset with a DIV in flight.
    send(OP_DIV, 32'h41000000, 32'h40000000, 5'd13, 32'h40800000, acc);
    idle(2);
    rst = 1'b1;
    iss_q.delete(); wb_q.delete(); rsp_q.delete();
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    t = cyc;
    send(OP_ADD, 32'h40000000, 32'h3F800000, 5'd14, 32'h40400000, acc);
    chk("accept_after_reset", acc, t);
    idle(20);
    @(negedge clk);
    chk("err_after_reset", {31'd0, err}, 32'd0);
    @(posedge clk); #1;

    // Illegal opcode: accepted, no issue, no writeback, err set.
    send(OP_BAD, 32'h1, 32'h2, 5'd15, 32'h0, acc);
    @(negedge clk);
    chk("err_illegal", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    idle(5);

    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("issue_queue_drained", iss_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_sched.md
FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports req_valid in 1, req_ready out 1  core issue handshake; accept = req_valid && req_ready.
REQ-004 SHALL have ports req_op in 6, req_a in 32, req_b in 32, req_rd in 5  FPU funct, operands, destination register.
REQ-005 SHALL have ports fpu_op_valid out 1, fpu_op out 6, fpu_a out 32, fpu_b out 32  issue to shared FP datapath.
REQ-006 SHALL have ports fpu_res_valid in 1, fpu_res in 32  datapath result strobe and data.
REQ-007 SHALL have port fpu_flush  out  1  drops datapath in-flight ops.
REQ-008 SHALL have ports wb_valid out 1, wb_rd out 5, wb_data out 32  register-file writeback.
REQ-009 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-010 SHALL use fixed result latencies L: ADD 000000 / SUB 000001 = 5; MUL 000010 = 3; DIV 000011 / SQRT 000100 = 12; C_EQ 110001 / C_LT 110010 / C_LE 110011 = 1; FTOI 011000 = 3; MOV 000110 / NEG 000111 / ABS 000101 = internal.
REQ-011 SHALL treat any other req_op as illegal: accepted, no issue, no writeback, err set.
REQ-012 SHALL keep a 16-entry slot shift register; entry k = {valid, rd, internal flag, internal data} for the result due k cycles ahead; shift by one every cycle.
REQ-013 SHALL, on accept in cycle t of an external op, drive fpu_op_valid=1 for exactly cycle t+1 with fpu_op/fpu_a/fpu_b registered from the request.
REQ-014 SHALL expect fpu_res_valid in cycle t+1+L; on it, drive wb_valid=1, wb_rd=slot rd, wb_data=fpu_res in cycle t+2+L.
REQ-015 SHALL compute internal ops without issue: MOV=a, NEG={~a[31],a[30:0]}, ABS={0,a[30:0]}; wb_valid in cycle t+2.
REQ-016 SHALL deassert req_ready (combinational) when any of: the slot due in cycle t+1+L already valid (writeback collision); req_rd matches rd of any valid slot (WAW); req_op is DIV/SQRT and a DIV/SQRT is still pending (non-pipelined unit); rst high.
REQ-017 SHALL drive fpu_op_valid low and fpu_op/fpu_a/fpu_b hold last value in every non-issue cycle.
REQ-018 SHALL allow up to 12 outstanding ops; back-to-back accepts of pipelined ops with distinct rd and distinct due cycles SHALL not stall.
REQ-019 SHALL set err on fpu_res_valid in a cycle with no external result due, or no fpu_res_valid when an external result is due; missing result produces no writeback.
REQ-020 SHALL present comparison results unchanged (datapath returns 0/1 in bit 0).
REQ-021 SHALL hold err until reset; err SHALL NOT stall issue.
REQ-022 SHALL drive wb_valid for exactly one cycle per completed op, never two ops same cycle.

Reset
REQ-023 SHALL, while rst high: clear all slots, fpu_op_valid=0, wb_valid=0, wb_rd=0, wb_data=0, fpu_op=0, fpu_a=0, fpu_b=0, err=0, req_ready=0, fpu_flush=1.
REQ-024 SHALL deassert fpu_flush in the first cycle after rst falls; req_ready may assert that cycle.
REQ-025 SHALL discard in-flight ops on reset mid-operation; no writeback of pre-reset ops.

Verification
REQ-026 ADD a=0x3F800000 b=0x40000000 rd=3 accepted cycle 0, model returns 0x40400000 cycle 6 -> fpu_op_valid cycle 1; wb_valid cycle 7, wb_rd=3, wb_data=0x40400000; err=0.
REQ-027 MUL rd=1 cycle 0 then ADD rd=2 cycle 1 (both due cycle 4 vs 7, no clash); then MUL rd=4 in cycle 3 (due cycle 7, clashes with ADD) -> req_ready=0 cycle 3, accepted cycle 4; writebacks rd1 cycle 5, rd2 cycle 8, rd4 cycle 9.
REQ-028 DIV rd=5 cycle 0, SQRT rd=6 presented cycle 1 -> req_ready low until DIV slot retires; SQRT accepted cycle 13; ADD rd=5 while DIV pending -> stalled (WAW).
REQ-029 NEG a=0x40400000 rd=7 cycle 0 -> no fpu_op_valid; wb cycle 2, wb_data=0xC0400000; C_LT a=1.0 b=2.0, model returns 1 -> wb_data=0x00000001.
REQ-030 Spurious fpu_res_valid with no pending op -> err=1 next cycle, stays 1; issue continues.
REQ-031 rst pulsed with DIV in flight -> fpu_flush=1 during rst, all outputs zero, no writeback for the DIV, new ADD accepted first cycle after rst.
